hack_control: RTL and testbench

HACK_CONTROL -- requirements
Module: hack_control

---
 rtl/hack_control.sv | 180 ++++++++++++++++++
 tb/tb_hack_control.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_control.sv
// hack_control -- multi-cycle control unit for a Hack-style CPU.
//
// Each instruction is fetched, decoded, and then either retired at once
// (A-instruction) or sent through an external registered ALU (C-instruction).
// The data memory and the ALU sit outside this block. Both respond one clock
// after they are driven.
//
// Ports:
//   clk, rst            rising-edge clock; asynchronous active-high reset
//   imem_addr/data/valid instruction fetch (imem_addr is always pc)
//   dmem_addr/wdata/we   data memory write path; dmem_rdata returns one clk later
//   dmem_rdata           data memory read data
//   alu_x, alu_y         ALU operands
//   zx..no               ALU control bits
//   alu_out              registered ALU result
//   a_reg, d_reg, pc     architectural state, exported for observation
//   halted               present only when HACK_CTRL_HALT_EN is defined
//
// Optional feature: define HACK_CTRL_HALT_EN to make an unconditional
// jump-to-self park the core in a HALT state. Only rst leaves that state.
module hack_control (
  input  logic        clk,
  input  logic        rst,
  output logic [14:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_valid,
  output logic [14:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  output logic        dmem_we,
  input  logic [15:0] dmem_rdata,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        zx,
  output logic        nx,
  output logic        zy,
  output logic        ny,
  output logic        f,
  output logic        no,
  input  logic [15:0] alu_out,
  output logic [15:0] a_reg,
  output logic [15:0] d_reg,
`ifdef HACK_CTRL_HALT_EN
  output logic [14:0] pc,
  output logic        halted
`else
  output logic [14:0] pc
`endif
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_MEMRD,
    S_EXEC,
    S_ALUWAIT,
    S_WB
`ifdef HACK_CTRL_HALT_EN
    , S_HALT
`endif
  } state_t;

  state_t      r_state;
  logic [15:0] r_ir;
  logic [15:0] r_a;
  logic [15:0] r_d;
  logic [14:0] r_pc;
  logic [15:0] r_m_val;
  logic        r_we;
  logic [15:0] r_alu_x;
  logic [15:0] r_alu_y;
  logic [5:0]  r_ctrl;
`ifdef HACK_CTRL_HALT_EN
  logic        r_halted;
`endif

  logic w_zr;
  logic w_ng;
  logic w_jump;
  logic [14:0] w_pc_inc;

  // The jump decision comes from the ALU result that is visible in WB.
  always_comb begin
    w_zr     = (alu_out == 16'h0000);
    w_ng     = alu_out[15];
    w_jump   = (r_ir[2] & w_ng) | (r_ir[1] & w_zr) | (r_ir[0] & ~w_ng & ~w_zr);
    w_pc_inc = r_pc + 15'd1;
  end

  // NOTE: all state is updated with non-blocking assignments. Every branch
  // then reads the old register values, for example the old a_reg used by
  // a jump target or a store address in WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_ir    <= '0;
      r_a     <= '0;
      r_d     <= '0;
      r_pc    <= '0;
      r_m_val <= '0;
      r_we    <= 1'b0;
      r_alu_x <= '0;
      r_alu_y <= '0;
      r_ctrl  <= '0;
`ifdef HACK_CTRL_HALT_EN
      r_halted <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_valid) begin
            r_ir    <= imem_data;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!r_ir[15]) begin
            r_a     <= r_ir;
            r_pc    <= w_pc_inc;
            r_state <= S_FETCH;
          end else begin
            // dmem_addr already shows a_reg, so rdata is ready in MEMRD.
            r_state <= r_ir[12] ? S_MEMRD : S_EXEC;
          end
        end
        S_MEMRD: begin
          r_m_val <= dmem_rdata;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_alu_x <= r_d;
          r_alu_y <= r_ir[12] ? r_m_val : r_a;
          r_ctrl  <= r_ir[11:6];
          r_state <= S_ALUWAIT;
        end
        S_ALUWAIT: begin
          // Operands hold steady here. The write strobe is raised so that
          // it is high during WB only.
          r_we    <= r_ir[3];
          r_state <= S_WB;
        end
        S_WB: begin
          r_we <= 1'b0;
          if (r_ir[5]) r_a <= alu_out;
          if (r_ir[4]) r_d <= alu_out;
          r_pc <= w_jump ? r_a[14:0] : w_pc_inc;
`ifdef HACK_CTRL_HALT_EN
          if ((r_ir[2:0] == 3'b111) && (r_a[14:0] == r_pc)) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else begin
            r_state <= S_FETCH;
          end
`else
          r_state <= S_FETCH;
`endif
        end
`ifdef HACK_CTRL_HALT_EN
        S_HALT: r_state <= S_HALT;
`endif
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // dmem_addr is old a_reg in both DECODE (read) and WB (store).
  assign imem_addr  = r_pc;
  assign dmem_addr  = r_a[14:0];
  assign dmem_wdata = alu_out;
  assign dmem_we    = r_we;
  assign alu_x      = r_alu_x;
  assign alu_y      = r_alu_y;
  assign {zx, nx, zy, ny, f, no} = r_ctrl;
  assign a_reg      = r_a;
  assign d_reg      = r_d;
  assign pc         = r_pc;
`ifdef HACK_CTRL_HALT_EN
  assign halted     = r_halted;
`endif

endmodule

// File: tb/tb_hack_control.sv
// tb_hack_control -- self-checking bench for hack_control.
// The bench supplies an instruction port, a registered data memory and a
// registered ALU. It also keeps an instruction-level reference model of
// A, D, PC and memory.
module tb_hack_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [14:0] imem_addr;
  logic [15:0] imem_data = '0;
  logic        imem_valid = 1'b0;
  logic [14:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_we;
  logic [15:0] dmem_rdata = '0;
  logic [15:0] alu_x, alu_y;
  logic        zx, nx, zy, ny, f, no;
  logic [15:0] alu_out = '0;
  logic [15:0] a_reg, d_reg;
  logic [14:0] pc;
`ifdef HACK_CTRL_HALT_EN
  logic        halted;
`endif

  hack_control dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_data(imem_data), .imem_valid(imem_valid),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
    .dmem_rdata(dmem_rdata),
    .alu_x(alu_x), .alu_y(alu_y),
    .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .alu_out(alu_out),
    .a_reg(a_reg), .d_reg(d_reg),
`ifdef HACK_CTRL_HALT_EN
    .pc(pc), .halted(halted)
`else
    .pc(pc)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Hack ALU as defined by its control bits.
  function automatic logic [15:0] alu_f(input logic [15:0] x, input logic [15:0] y,
                                        input logic [5:0] c);
    logic [15:0] a, b, o;
    a = c[5] ? 16'h0 : x;
    if (c[4]) a = ~a;
    b = c[3] ? 16'h0 : y;
    if (c[2]) b = ~b;
    o = c[1] ? a + b : a & b;
    if (c[0]) o = ~o;
    return o;
  endfunction

  // Environment: registered data memory and registered ALU.
  logic [15:0] env_mem [0:32767];
  always @(posedge clk) begin
    if (dmem_we) env_mem[dmem_addr] <= dmem_wdata;
    dmem_rdata <= env_mem[dmem_addr];
    alu_out    <= alu_f(alu_x, alu_y, {zx, nx, zy, ny, f, no});
  end

  // Reference model state, updated once per instruction.
  logic [15:0] ref_mem [0:32767];
  logic [15:0] m_a, m_d;
  logic [14:0] m_pc;

  task automatic model_exec(input logic [15:0] w, output logic st,
                            output logic [14:0] st_addr, output logic [15:0] st_data);
    logic [15:0] old_a, y, o;
    logic        jump;
    st = 1'b0; st_addr = '0; st_data = '0;
    if (!w[15]) begin
      m_a  = w;
      m_pc = m_pc + 15'd1;
    end else begin
      old_a = m_a;
      y     = w[12] ? ref_mem[old_a[14:0]] : old_a;
      o     = alu_f(m_d, y, w[11:6]);
      jump  = (w[2] && ($signed(o) < 0)) || (w[1] && (o == 0)) || (w[0] && ($signed(o) > 0));
      if (w[3]) begin
        st = 1'b1; st_addr = old_a[14:0]; st_data = o;
        ref_mem[old_a[14:0]] = o;
      end
      if (w[5]) m_a = o;
      if (w[4]) m_d = o;
      m_pc = jump ? old_a[14:0] : m_pc + 15'd1;
    end
  endtask

  // Issue one instruction from FETCH and wait the cycles it should take.
  // Random imem_valid in later cycles must be ignored.
  task automatic run_instr(input logic [15:0] w);
    logic        st;
    logic [14:0] st_addr, we_addr;
    logic [15:0] st_data, we_data;
    int          n, we_cnt;
    check("imem_addr_fetch", imem_addr, m_pc);
    model_exec(w, st, st_addr, st_data);
    imem_data  = w;
    imem_valid = 1'b1;
    @(posedge clk); #1;
    n = !w[15] ? 1 : (w[12] ? 5 : 4);
    we_cnt = 0; we_addr = '0; we_data = '0;
    repeat (n) begin
      imem_valid = 1'($urandom);
      imem_data  = 16'($urandom);
      @(negedge clk);
      if (dmem_we) begin
        we_cnt++;
        we_addr = dmem_addr;
        we_data = dmem_wdata;
      end
      @(posedge clk); #1;
    end
    imem_valid = 1'b0;
    check("a_reg", a_reg, m_a);
    check("d_reg", d_reg, m_d);
    check("pc", pc, m_pc);
    check("we_pulses", we_cnt, st ? 1 : 0);
    if (st) begin
      check("st_addr", we_addr, st_addr);
      check("st_data", we_data, st_data);
      check("mem_after_st", env_mem[st_addr], ref_mem[st_addr]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_valid = 1'b0;
    #2;
    check("rst_a", a_reg, 0);
    check("rst_d", d_reg, 0);
    check("rst_pc", pc, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_we", dmem_we, 0);
    check("rst_alu_xy", {alu_x, alu_y}, 0);
    check("rst_ctrl", {zx, nx, zy, ny, f, no}, 0);
`ifdef HACK_CTRL_HALT_EN
    check("rst_halted", halted, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    m_a = '0; m_d = '0; m_pc = '0;
    @(posedge clk); #1;
  endtask

  task automatic set_mem(input logic [14:0] addr, input logic [15:0] v);
    env_mem[addr] = v;
    ref_mem[addr] = v;
  endtask

  initial begin
    logic [15:0] w, w0;
    logic [14:0] pc_hold;
    int          we_seen;
    for (int i = 0; i < 32768; i++) begin
      w0 = 16'($urandom);
      env_mem[i] = w0;
      ref_mem[i] = w0;
    end
    m_a = '0; m_d = '0; m_pc = '0;
    @(negedge clk);
    do_reset();

    // A=5 then D=A.
    run_instr(16'h0005);
    run_instr(16'hEC10);
    check("dA_ctrl", {zx, nx, zy, ny, f, no}, 6'b110000);
    check("dA_pc2", pc, 2);

    // M=D+M: D=3 and M[100]=7 give a store of 10.
    set_mem(15'd100, 16'd7);
    run_instr(16'h0003);
    run_instr(16'hEC10);
    run_instr(16'd100);
    run_instr(16'hF088);
    check("mdm_mem100", env_mem[100], 16'd10);

    // AM=M-1: a store of 0 to address 20, and A becomes 0.
    set_mem(15'd20, 16'd1);
    run_instr(16'd20);
    run_instr(16'hFCA8);
    check("amm_mem20", env_mem[20], 16'd0);
    check("amm_a", a_reg, 16'd0);

    // Conditional jumps.
    run_instr(16'hEA90);           // D=0
    run_instr(16'd40);
    run_instr(16'hE302);           // D;JEQ taken
    check("jeq_taken", pc, 40);
    run_instr(16'hEE90);           // D=-1
    run_instr(16'd40);
    pc_hold = pc;
    run_instr(16'hE302);           // D;JEQ not taken
    check("jeq_fall", pc, pc_hold + 15'd1);
    run_instr(16'd40);
    run_instr(16'hE304);           // D;JLT taken
    check("jlt_taken", pc, 40);

    // imem_valid low for 5 cycles in FETCH: nothing changes.
    pc_hold = pc;
    repeat (5) begin @(posedge clk); #1; end
    check("stall_pc", pc, pc_hold);
    check("stall_a", a_reg, m_a);

    // PC wraps from 0x7FFF to 0.
    run_instr(16'h7FFF);
    run_instr(16'hEA87);           // 0;JMP
    check("jmp_7fff", pc, 15'h7FFF);
    run_instr(16'h0001);
    check("pc_wrap", pc, 0);

    // Reset during ALUWAIT of D=D+1 abandons the instruction.
    run_instr(16'h0005);
    run_instr(16'hEC10);           // D=5
    imem_data = 16'hE7D0; imem_valid = 1'b1;
    @(posedge clk); #1; imem_valid = 1'b0;   // DECODE
    we_seen = 0;
    repeat (2) begin
      @(negedge clk); if (dmem_we) we_seen++;
      @(posedge clk); #1;                    // EXEC, then ALUWAIT
    end
    check("aluwait_we", we_seen + int'(dmem_we), 0);
    #2;
    do_reset();
    check("post_rst_fetch0", imem_addr, 0);

    // Randomised instruction stream.
    for (int k = 0; k < 300; k++) begin
      w = 16'($urandom);
`ifdef HACK_CTRL_HALT_EN
      if (w[15] && w[2:0] == 3'b111) w[0] = 1'b0;
`endif
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      run_instr(w);
    end

`ifdef HACK_CTRL_HALT_EN
    // A jump-to-self halts the core. Only rst exits.
    do_reset();
    run_instr(16'h0000);
    run_instr(16'h0000);
    run_instr(16'h0003);
    imem_data = 16'hEA87; imem_valid = 1'b1;
    @(posedge clk); #1;
    imem_valid = 1'b1;
    repeat (9) begin @(posedge clk); #1; end
    check("halt_flag", halted, 1);
    check("halt_pc", pc, 3);
    check("halt_we", dmem_we, 0);
    imem_valid = 1'b0;
    do_reset();
    check("halt_cleared", halted, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
